// File: rtl/slurm16_periph_pkg.sv
// Shared constants for slurm16 peripheral bus blocks: data width and the
// gpio_irq_ctrl register map.
package slurm16_periph_pkg;

    localparam int unsigned BUS_DW      = 16;
    localparam int unsigned GPIO_IRQ_AW = 3;

    localparam logic [GPIO_IRQ_AW-1:0] GPIO_IRQ_LEVEL   = 3'd0;
    localparam logic [GPIO_IRQ_AW-1:0] GPIO_IRQ_RISE_EN = 3'd1;
    localparam logic [GPIO_IRQ_AW-1:0] GPIO_IRQ_FALL_EN = 3'd2;
    localparam logic [GPIO_IRQ_AW-1:0] GPIO_IRQ_PENDING = 3'd3;
    localparam logic [GPIO_IRQ_AW-1:0] GPIO_IRQ_MASK    = 3'd4;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO channel: two-flop synchroniser followed by an optional
// glitch-rejecting counter filter.
// Config macro: GPIO_IRQ_DEBOUNCE_EN (defined = counter filter present,
// undefined = level follows the synchroniser output directly).
// Ports:
//   CLK, RSTb        clock, async active-low reset
//   pin_in           raw asynchronous pin
//   level            filtered input level
module gpio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic CLK,
    input  logic RSTb,
    input  logic pin_in,
    output logic level
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
        $error("gpio_debounce: DEBOUNCE_CYCLES out of range 2..255");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    // Synchroniser stages
    always_comb begin
        sync1_d = pin_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    // Count consecutive mismatch cycles; accept the new level on the last one.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO input and interrupt controller: N_CH filtered inputs, per-channel
// rise/fall event enables, W1C pending register, mask and a registered irq.
// Config macro: GPIO_IRQ_DEBOUNCE_EN (enables the per-channel counter filter).
// Ports:
//   CLK, RSTb        clock, async active-low reset
//   gpio_in          raw pin inputs
//   addr/wr_en/wr_data/rd_en   register access
//   rd_data          registered read data, held between reads
//   irq              registered |(PENDING & MASK)
module gpio_irq_ctrl
    import slurm16_periph_pkg::*;
#(
    parameter int unsigned N_CH            = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                   CLK,
    input  logic                   RSTb,
    input  logic [N_CH-1:0]        gpio_in,
    input  logic [GPIO_IRQ_AW-1:0] addr,
    input  logic                   wr_en,
    input  logic [BUS_DW-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [BUS_DW-1:0]      rd_data,
    output logic                   irq
);

    if (N_CH < 1 || N_CH > 16) begin : g_bad_cfg
        $error("gpio_irq_ctrl: N_CH out of range 1..16");
    end

    logic [N_CH-1:0]   level;
    logic [N_CH-1:0]   level_dly_q, level_dly_d;
    logic [N_CH-1:0]   rise_en_q, rise_en_d;
    logic [N_CH-1:0]   fall_en_q, fall_en_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [BUS_DW-1:0] rd_data_q, rd_data_d;
    logic              irq_q, irq_d;
    logic [N_CH-1:0]   evt;
    logic [N_CH-1:0]   w1c;
    logic [N_CH-1:0]   rd_sel;
    logic [N_CH-1:0]   wr_bits;
    logic              wr_data_unused;

    // Bits above N_CH are deliberately ignored on writes.
    assign wr_bits        = wr_data[N_CH-1:0];
    assign wr_data_unused = ^wr_data;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK    (CLK),
            .RSTb   (RSTb),
            .pin_in (gpio_in[i]),
            .level  (level[i])
        );
    end

    // Register file, edge detect and interrupt combine
    always_comb begin
        level_dly_d = level;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        mask_d      = mask_q;
        w1c         = '0;
        rd_sel      = '0;

        evt = (level & ~level_dly_q & rise_en_q) | (~level & level_dly_q & fall_en_q);

        if (wr_en) begin
            case (addr)
                GPIO_IRQ_RISE_EN: rise_en_d = wr_bits;
                GPIO_IRQ_FALL_EN: fall_en_d = wr_bits;
                GPIO_IRQ_PENDING: w1c       = wr_bits;
                GPIO_IRQ_MASK:    mask_d    = wr_bits;
                default:          ;
            endcase
        end

        // A hardware set in the same cycle as a W1C keeps the bit set.
        pending_d = (pending_q & ~w1c) | evt;
        irq_d     = |(pending_q & mask_q);

        case (addr)
            GPIO_IRQ_LEVEL:   rd_sel = level;
            GPIO_IRQ_RISE_EN: rd_sel = rise_en_q;
            GPIO_IRQ_FALL_EN: rd_sel = fall_en_q;
            GPIO_IRQ_PENDING: rd_sel = pending_q;
            GPIO_IRQ_MASK:    rd_sel = mask_q;
            default:          rd_sel = '0;
        endcase
        rd_data_d = rd_en ? BUS_DW'(rd_sel) : rd_data_q;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            level_dly_q <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            rd_data_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            level_dly_q <= level_dly_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            rd_data_q   <= rd_data_d;
            irq_q       <= irq_d;
        end
    end

    assign rd_data = rd_data_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Bench for gpio_irq_ctrl (N_CH=6, DEBOUNCE_CYCLES=4). Expectations are
// queued by the stimulus thread; a monitor checks rd_data/irq after each
// sampled read. Latency follows GPIO_IRQ_DEBOUNCE_EN.
module tb_gpio_irq_ctrl;
    import slurm16_periph_pkg::*;

    localparam int unsigned N_CH = 6;
    localparam int unsigned DBC  = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int unsigned LAT = DBC;
`else
    localparam int unsigned LAT = 0;
`endif

    typedef struct {
        string       name;
        logic [15:0] rd;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    logic            CLK = 1'b0;
    logic            RSTb;
    logic [N_CH-1:0] gpio_in;
    logic [2:0]      addr;
    logic            wr_en;
    logic [15:0]     wr_data;
    logic            rd_en;
    logic [15:0]     rd_data;
    logic            irq;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic rd_fire;

    gpio_irq_ctrl #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (DBC)
    ) dut (
        .CLK     (CLK),
        .RSTb    (RSTb),
        .gpio_in (gpio_in),
        .addr    (addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .irq     (irq)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Remember which edges sampled a read
    always @(posedge CLK or negedge RSTb) begin
        if (!RSTb) rd_fire <= 1'b0;
        else       rd_fire <= rd_en;
    end

    // Monitor: one expectation per sampled read
    always @(negedge CLK) begin
        if (rd_fire) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: read seen with rd_data=%h but nothing expected", rd_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (rd_data !== e.rd) begin
                    bad++;
                    $display("FAIL %s rd_data: got %h want %h", e.name, rd_data, e.rd);
                end
                if (e.chk_irq) begin
                    total++;
                    if (irq !== e.irq) begin
                        bad++;
                        $display("FAIL %s irq: got %b want %b", e.name, irq, e.irq);
                    end
                end
            end
        end
    end

    task automatic push(input string n, input logic [15:0] v, input bit ci, input logic ei);
        exp_t e;
        e.name = n; e.rd = v; e.chk_irq = ci; e.irq = ei;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] v, input string n,
                      input bit ci, input logic ei);
        addr = a; rd_en = 1'b1;
        push(n, v, ci, ei);
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        addr = a; wr_data = d; wr_en = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    // Write and read the same register in one cycle (read returns old value)
    task automatic wrrd(input logic [2:0] a, input logic [15:0] d, input logic [15:0] v,
                        input string n, input logic ei);
        addr = a; wr_data = d; wr_en = 1'b1; rd_en = 1'b1;
        push(n, v, 1'b1, ei);
        @(negedge CLK);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        RSTb = 1'b0; gpio_in = '0; addr = '0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
        repeat (3) @(negedge CLK);
        RSTb = 1'b1;
        @(negedge CLK);

        // Reset values on all eight addresses
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, "reset_rd", 1'b1, 1'b0);

        // Rising edge on ch0; upper write bits dropped
        wr(GPIO_IRQ_RISE_EN, 16'hFFC1);
        wr(GPIO_IRQ_MASK, 16'h0001);
        rd(GPIO_IRQ_RISE_EN, 16'h0001, "rise_en_rb", 1'b1, 1'b0);
        gpio_in[0] = 1'b1; addr = GPIO_IRQ_PENDING; rd_en = 1'b1;
        for (int k = 1; k <= 6 + int'(LAT); k++) begin
            push("rise_timing", (k >= 4 + int'(LAT)) ? 16'h0001 : 16'h0000,
                 1'b1, (k >= 4 + int'(LAT)));
            @(negedge CLK);
        end
        rd_en = 1'b0;
        wrrd(GPIO_IRQ_PENDING, 16'h0001, 16'h0001, "w1c_edge", 1'b1);
        rd(GPIO_IRQ_PENDING, 16'h0000, "w1c_after", 1'b1, 1'b0);

        // Glitch rejection
        wr(GPIO_IRQ_RISE_EN, 16'h003F);
        wr(GPIO_IRQ_FALL_EN, 16'h003F);
        wr(GPIO_IRQ_MASK, 16'h0000);
        gpio_in[2] = 1'b1;
        repeat (3) @(negedge CLK);
        gpio_in[2] = 1'b0;
        repeat (12) @(negedge CLK);
        rd(GPIO_IRQ_PENDING, (LAT == 0) ? 16'h0004 : 16'h0000, "glitch3", 1'b1, 1'b0);
        wr(GPIO_IRQ_PENDING, 16'h003F);
        gpio_in[2] = 1'b1;
        repeat (4) @(negedge CLK);
        gpio_in[2] = 1'b0;
        repeat (16) @(negedge CLK);
        rd(GPIO_IRQ_PENDING, 16'h0004, "pulse4", 1'b1, 1'b0);
        wr(GPIO_IRQ_PENDING, 16'h003F);
        rd(GPIO_IRQ_PENDING, 16'h0000, "clr_all", 1'b0, 1'b0);

        // Single-cycle pulse on ch1: both edges without filter, nothing with it
        addr = GPIO_IRQ_PENDING; rd_en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            gpio_in[1] = (k == 1);
            push("pulse1", (LAT == 0 && k >= 4) ? 16'h0002 : 16'h0000, 1'b1, 1'b0);
            @(negedge CLK);
        end
        rd_en = 1'b0;
        wr(GPIO_IRQ_PENDING, 16'h003F);

        // Event while masked, then unmask and remask
        gpio_in[5] = 1'b1;
        repeat (6 + LAT) @(negedge CLK);
        rd(GPIO_IRQ_PENDING, 16'h0020, "masked_pend", 1'b1, 1'b0);
        wrrd(GPIO_IRQ_MASK, 16'h0020, 16'h0000, "unmask_edge", 1'b0);
        rd(GPIO_IRQ_MASK, 16'h0020, "unmask_next", 1'b1, 1'b1);
        wrrd(GPIO_IRQ_MASK, 16'h0000, 16'h0020, "remask_edge", 1'b1);
        rd(GPIO_IRQ_PENDING, 16'h0020, "remask_next", 1'b1, 1'b0);

        // Set/clear collision on ch3
        wr(GPIO_IRQ_PENDING, 16'h003F);
        rd(GPIO_IRQ_PENDING, 16'h0000, "pre_collide", 1'b0, 1'b0);
        gpio_in[3] = 1'b1;
        repeat (2 + LAT) @(negedge CLK);
        wr(GPIO_IRQ_PENDING, 16'h0008);
        rd(GPIO_IRQ_PENDING, 16'h0008, "collide", 1'b1, 1'b0);
        wr(GPIO_IRQ_PENDING, 16'h0008);
        rd(GPIO_IRQ_PENDING, 16'h0000, "post_collide", 1'b0, 1'b0);

        // Reserved address and filtered level
        wr(3'd6, 16'hFFFF);
        rd(3'd6, 16'h0000, "reserved", 1'b0, 1'b0);
        rd(GPIO_IRQ_LEVEL, 16'h0029, "level", 1'b1, 1'b0);
        rd(GPIO_IRQ_FALL_EN, 16'h003F, "fall_en_rb", 1'b0, 1'b0);

        repeat (3) @(negedge CLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
